vga_scan_ctrl: RTL

//  Scan controller for the PPU/VGA frame buffer read port. Generates 640x480@60 VGA timing,

---
 rtl/vga_scan_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA 640x480 timing with 2x-scaled, centred frame-buffer scan and
// a two-tick address/output pipeline matched to the frame buffer read latency.
module vga_scan_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int X_OFF  = 64,
  parameter int IMG_W  = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       scan_en,
  output logic [9:0] mem_row,
  output logic [9:0] mem_col,
  input  logic [7:0] mem_data,
  output logic [7:0] pix_out,
  output logic       de,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vblank,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_V    = 10'(H_VIS);
  localparam logic [9:0] V_V    = 10'(V_VIS);
  localparam logic [9:0] HS_B   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_B   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] IMG_B  = 10'(X_OFF);
  localparam logic [9:0] IMG_E  = 10'(X_OFF + IMG_W);
  logic [9:0] h_cnt, v_cnt, col;
  logic       en_lat, vis0, img0, hs0_n, vs0_n;
  logic       h_last, v_last, vis, img;
  assign h_last = h_cnt == H_LAST;
  assign v_last = v_cnt == V_LAST;
  assign vis    = h_cnt < H_V && v_cnt < V_V;
  assign img    = en_lat && v_cnt < V_V && h_cnt >= IMG_B && h_cnt < IMG_E;
  assign col    = h_cnt - IMG_B;
  assign vblank = v_cnt >= V_V;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      en_lat      <= 1'b0;
      mem_row     <= 10'h3FF;
      mem_col     <= 10'h3FF;
      vis0        <= 1'b0;
      img0        <= 1'b0;
      hs0_n       <= 1'b1;
      vs0_n       <= 1'b1;
      pix_out     <= '0;
      de          <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && h_cnt == '0 && v_cnt == '0;
      if (pix_ce) begin
        h_cnt   <= h_last ? '0 : h_cnt + 10'd1;
        v_cnt   <= h_last ? (v_last ? '0 : v_cnt + 10'd1) : v_cnt;
        // the enable is only ever picked up on the last tick of a frame
        if (h_last && v_last) en_lat <= scan_en;
        mem_col <= img ? {1'b0, col[9:1]} : 10'h3FF;
        mem_row <= img ? {1'b0, v_cnt[9:1]} : 10'h3FF;
        vis0    <= vis;
        img0    <= img;
        hs0_n   <= !(h_cnt >= HS_B && h_cnt < HS_E);
        vs0_n   <= !(v_cnt >= VS_B && v_cnt < VS_E);
        de      <= vis0;
        pix_out <= img0 ? mem_data : '0;
        hsync_n <= hs0_n;
        vsync_n <= vs0_n;
      end
    end
endmodule
